// File: rtl/seq_ctrl_pkg.sv
// Shared types and default sizing for the serial pattern-detect controller.
// No logic; imported by seq_match_window and seq_detect_controller.
// Optional match interrupt is selected by SEQ_CTRL_MATCH_IRQ_EN in the top.
package seq_ctrl_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int PAT_W_DEF  = 5;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/seq_match_window.sv
// Overlapping match window: bit history, bits-seen counter and masked compare.
// Latency: match registered one cycle after the completing bit; match_nxt is the same-cycle view.
// Backpressure: none, consumes a bit whenever in_vld is high.
module seq_match_window
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_bit,
    input  logic                       in_vld,
    input  logic                       clear,
    input  logic [PAT_W-1:0]           pattern,
    input  logic [$clog2(PAT_W+1)-1:0] len,
    output logic                       match,
    output logic                       match_nxt
);

    localparam int LEN_W = $clog2(PAT_W+1);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] seen_q, seen_d;
    logic             match_q;

    always_comb begin
        hist_d    = hist_q;
        seen_d    = seen_q;
        if (clear) begin
            hist_d = '0;
            seen_d = '0;
        end else if (in_vld) begin
            hist_d = PAT_W'({hist_q, in_bit});
            if (seen_q != LEN_W'(PAT_W))
                seen_d = seen_q + 1'b1;
        end
        // len == PAT_W shifts every bit out, giving a full mask
        mask      = ~({PAT_W{1'b1}} << len);
        match_nxt = in_vld && !clear
                    && (((hist_d ^ pattern) & mask) == '0)
                    && (seen_d >= len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            seen_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            seen_q  <= seen_d;
            match_q <= match_nxt;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/seq_detect_controller.sv
// Frame controller: serializes words MSB-first into the match window, counts matches, reports per frame.
// Latency: WORD_W+1 cycles from word accept until in_ready returns; result valid the edge after the last bit.
// Backpressure: in_ready only in IDLE; REPORT holds until res_ready. SEQ_CTRL_MATCH_IRQ_EN adds irq/irq_clr.
module seq_detect_controller
    import seq_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int PAT_W  = PAT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_W-1:0]          in_data,
    input  logic                       in_last,
    output logic                       serial_bit,
    output logic                       serial_valid,
    output logic                       match_pulse,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [CNT_W-1:0]           res_count,
    output logic                       res_saturated,
`ifdef SEQ_CTRL_MATCH_IRQ_EN
    input  logic                       irq_clr,
    output logic                       irq,
`endif
    output logic                       busy
);

    localparam int LEN_W = $clog2(PAT_W+1);
    localparam int BC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic              last_q, last_d;
    logic              open_q, open_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sat_q, sat_d;
    logic              win_clear;
    logic              match_nxt;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bitcnt_d  = bitcnt_q;
        last_d    = last_q;
        open_d    = open_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        count_d   = count_q;
        sat_d     = sat_q;
        win_clear = 1'b0;

        // A write in the accept cycle lands before the word's first bit is shifted
        if (cfg_we && state_q == IDLE && !open_q) begin
            pattern_d = cfg_pattern;
            if (cfg_len == '0)
                len_d = LEN_W'(1);
            else if (cfg_len > LEN_W'(PAT_W))
                len_d = LEN_W'(PAT_W);
            else
                len_d = cfg_len;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d   = in_data;
                    bitcnt_d = BC_W'(WORD_W-1);
                    last_d   = in_last;
                    open_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d   = sreg_q << 1;
                bitcnt_d = bitcnt_q - 1'b1;
                if (bitcnt_q == '0)
                    state_d = last_q ? REPORT : IDLE;
            end
            REPORT: begin
                if (res_ready) begin
                    count_d   = '0;
                    sat_d     = 1'b0;
                    open_d    = 1'b0;
                    win_clear = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (match_nxt) begin
            if (count_q == '1)
                sat_d = 1'b1;
            else
                count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bitcnt_q  <= '0;
            last_q    <= 1'b0;
            open_q    <= 1'b0;
            pattern_q <= '1;
            len_q     <= LEN_W'(PAT_W);
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bitcnt_q  <= bitcnt_d;
            last_q    <= last_d;
            open_q    <= open_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
        end
    end

    seq_match_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (sreg_q[WORD_W-1]),
        .in_vld    (state_q == SHIFT),
        .clear     (win_clear),
        .pattern   (pattern_q),
        .len       (len_q),
        .match     (match_pulse),
        .match_nxt (match_nxt)
    );

    assign in_ready      = (state_q == IDLE);
    assign serial_valid  = (state_q == SHIFT);
    assign serial_bit    = (state_q == SHIFT) & sreg_q[WORD_W-1];
    assign res_valid     = (state_q == REPORT);
    assign res_count     = count_q;
    assign res_saturated = sat_q;
    assign busy          = (state_q != IDLE) || open_q;

`ifdef SEQ_CTRL_MATCH_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = match_pulse | (irq_q & ~irq_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_q <= 1'b0;
        else
            irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_seq_detect_controller.sv
// Directed bench for seq_detect_controller: a default instance plus a CNT_W=2 instance on shared stimulus.
module tb_seq_detect_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [4:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       in_valid;
    logic       in_ready, in_ready2;
    logic [7:0] in_data;
    logic       in_last;
    logic       serial_bit, serial_bit2;
    logic       serial_valid, serial_valid2;
    logic       match_pulse, match_pulse2;
    logic       res_valid, res_valid2;
    logic       res_ready;
    logic [7:0] res_count;
    logic [1:0] res_count2;
    logic       res_saturated, res_saturated2;
    logic       busy, busy2;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic        mon_clr  = 1'b0;
    logic [31:0] ser_bits = '0;
    int          ser_n    = 0;
    logic [31:0] pulse_mask = '0;
    int          pulses2  = 0;

    always #5 clk = ~clk;

    seq_detect_controller u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .serial_bit(serial_bit), .serial_valid(serial_valid), .match_pulse(match_pulse),
        .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
        .res_saturated(res_saturated), .busy(busy)
    );

    seq_detect_controller #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .serial_bit(serial_bit2), .serial_valid(serial_valid2), .match_pulse(match_pulse2),
        .res_valid(res_valid2), .res_ready(res_ready), .res_count(res_count2),
        .res_saturated(res_saturated2), .busy(busy2)
    );

    // Records serialized bits and, per pulse, the number of bits presented before it
    always @(negedge clk) begin
        if (mon_clr) begin
            ser_bits   = '0;
            ser_n      = 0;
            pulse_mask = '0;
            pulses2    = 0;
        end else begin
            if (match_pulse)  pulse_mask = pulse_mask | (32'd1 << ser_n);
            if (match_pulse2) pulses2++;
            if (serial_valid) begin
                ser_bits = {ser_bits[30:0], serial_bit};
                ser_n++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_cfg(input logic [4:0] p, input logic [2:0] l);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_we      = 1'b1;
        @(posedge clk); #1;
        cfg_we      = 1'b0;
    endtask

    task automatic start_frame();
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input int exp_cnt, input logic exp_sat,
                              input logic [31:0] exp_mask);
        int n = 0;
        while (!res_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!res_valid) chk({tag, "_res_timeout"}, {31'd0, res_valid}, 32'd1);
        @(negedge clk); #1;
        chk({tag, "_count"}, {24'd0, res_count}, exp_cnt);
        chk({tag, "_sat"}, {31'd0, res_saturated}, {31'd0, exp_sat});
        chk({tag, "_pulses"}, pulse_mask, exp_mask);
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_rel_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_rel_count"}, {24'd0, res_count}, 32'd0);
        chk({tag, "_rel_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_ser_valid"}, {31'd0, serial_valid}, 32'd0);
        chk({tag, "_ser_bit"}, {31'd0, serial_bit}, 32'd0);
        chk({tag, "_match"}, {31'd0, match_pulse}, 32'd0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_res_count"}, {24'd0, res_count}, 32'd0);
        chk({tag, "_res_sat"}, {31'd0, res_saturated}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: two overlapping-window matches inside one word
        do_cfg(5'b11011, 3'd5);
        start_frame();
        send(8'hDB, 1'b1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        get_result("t1", 2, 1'b0, 32'h120);
        chk("t1_serial", ser_bits, 32'h0000_00DB);
        chk("t1_nbits", ser_n, 32'd8);
        release_result("t1");

        // 2: match spans the word boundary
        do_cfg(5'b01101, 3'd4);
        start_frame();
        send(8'h01, 1'b0);
        send(8'hA0, 1'b1);
        get_result("t2", 1, 1'b0, 32'h800);
        chk("t2_serial", ser_bits, 32'h0000_01A0);
        release_result("t2");

        // 3: single-bit pattern, all-ones word; the CNT_W=2 instance saturates
        do_cfg(5'b00001, 3'd1);
        start_frame();
        send(8'hFF, 1'b1);
        get_result("t3", 8, 1'b0, 32'h1FE);
        chk("t3_small_count", {30'd0, res_count2}, 32'd3);
        chk("t3_small_sat", {31'd0, res_saturated2}, 32'd1);
        chk("t3_small_pulses", pulses2, 32'd8);
        release_result("t3");

        // 4: result held while res_ready stays low
        do_cfg(5'b11011, 3'd5);
        start_frame();
        send(8'hDB, 1'b1);
        get_result("t4", 2, 1'b0, 32'h120);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("t4_hold_valid", {31'd0, res_valid}, 32'd1);
            chk("t4_hold_count", {24'd0, res_count}, 32'd2);
            chk("t4_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        release_result("t4");

        // 5: config write during SHIFT has no effect
        start_frame();
        send(8'hDB, 1'b1);
        do_cfg(5'b00000, 3'd5);
        get_result("t5", 2, 1'b0, 32'h120);
        release_result("t5");

        // 6: reset mid-word aborts the frame; pattern returns to all-ones, len 5
        start_frame();
        send(8'hFF, 1'b1);
        for (int i = 0; i < 20 && ser_n < 4; i++) begin
            @(negedge clk); #1;
        end
        chk("t6_at_bit4", ser_n, 32'd4);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_frame();
        send(8'hFF, 1'b1);
        get_result("t6", 4, 1'b0, 32'h1E0);
        release_result("t6");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
